// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared defaults and FSM state type for the whack-a-mole
//               switch input path.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

  localparam int N_SW            = 18;
  localparam int POS_W           = 5;
  localparam int DEBOUNCE_CYCLES = 500000;
  localparam int CNT_W           = 19;

  // Event handshake state: no event outstanding, or one event waiting for ack
  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } fsm_state_t;

endpackage : game_pkg
`default_nettype wire

// File: rtl/switch_hit_detector_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : switch_debouncer
// Description : One switch bit: 2-FF synchroniser, stability counter,
//               debounced level and a one-cycle toggle strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_debouncer
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = game_pkg::DEBOUNCE_CYCLES,
  parameter int CNT_W           = game_pkg::CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sw,
  output logic o_stable,
  output logic o_toggle
);

  // Counter value after which one more mismatching cycle commits the new level
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_toggle;
  logic [CNT_W-1:0] r_cnt;

  // Bring the asynchronous switch into the clock domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_sw;
      r_sync2 <= r_sync1;
    end
  end

  // Count consecutive cycles the synced level differs from the debounced one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
      r_toggle <= 1'b0;
    end else if (r_sync2 == r_stable) begin
      r_cnt    <= '0;
      r_toggle <= 1'b0;
    end else if (r_cnt == c_CNT_LAST) begin
      r_cnt    <= '0;
      r_stable <= r_sync2;
      r_toggle <= 1'b1;
    end else begin
      r_cnt    <= r_cnt + 1'b1;
      r_toggle <= 1'b0;
    end
  end

  assign o_stable = r_stable;
  assign o_toggle = r_toggle;

endmodule : switch_debouncer
`default_nettype wire

// File: rtl/switch_hit_detector.sv
`default_nettype none
// ============================================================================
// Module      : switch_hit_detector
// Description : Debounces the player switches, picks one toggle per cycle,
//               classifies it against the target LED and presents it to the
//               game controller through a valid/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_hit_detector
  import game_pkg::*;
#(
  parameter int N_SW            = game_pkg::N_SW,
  parameter int POS_W           = game_pkg::POS_W,
  parameter int DEBOUNCE_CYCLES = game_pkg::DEBOUNCE_CYCLES,
  parameter int CNT_W           = game_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SW-1:0]  i_switches,
  input  logic [N_SW-1:0]  i_target_led,
  input  logic             i_enable,
  input  logic             i_event_ack,
  input  logic             i_clr_ovf,
  output logic             o_event_valid,
  output logic             o_event_hit,
  output logic [POS_W-1:0] o_event_pos,
  output logic [N_SW-1:0]  o_sw_stable,
  output logic             o_overflow
);

  // Arming waits out the full power-on debounce latency so that switches
  // already up at reset settle into sw_stable without producing events.
  localparam int              ARM_W      = CNT_W + 1;
  localparam logic [ARM_W-1:0] c_ARM_LAST = ARM_W'(DEBOUNCE_CYCLES + 2);

  logic [N_SW-1:0]  w_toggle;
  logic             w_any;
  logic             w_multi;
  logic             w_found;
  logic             w_hit;
  logic [POS_W-1:0] w_pos;
  logic             w_take;
  logic             w_load;
  logic             w_drop;
  logic             w_ovf_set;
  fsm_state_t       w_state_nxt;

  fsm_state_t       r_state;
  logic [ARM_W-1:0] r_arm_cnt;
  logic             r_armed;
  logic             r_valid;
  logic             r_hit;
  logic [POS_W-1:0] r_pos;
  logic             r_ovf;

  genvar gi;
  generate
    for (gi = 0; gi < N_SW; gi++) begin : g_debounce
      switch_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .i_sw     (i_switches[gi]),
        .o_stable (o_sw_stable[gi]),
        .o_toggle (w_toggle[gi])
      );
    end
  endgenerate

  // Lowest-index toggle wins; flag when more than one fired this cycle
  always_comb begin
    w_pos   = '0;
    w_hit   = 1'b0;
    w_found = 1'b0;
    w_multi = 1'b0;
    for (int i = 0; i < N_SW; i++) begin
      if (w_toggle[i]) begin
        if (w_found) begin
          w_multi = 1'b1;
        end else begin
          w_found = 1'b1;
          w_pos   = POS_W'(i);
          w_hit   = i_target_led[i];
        end
      end
    end
    w_any = w_found;
  end

  // Count cycles since reset release until the detector is armed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_arm_cnt <= '0;
      r_armed   <= 1'b0;
    end else if (!r_armed) begin
      if (r_arm_cnt == c_ARM_LAST) begin
        r_armed <= 1'b1;
      end else begin
        r_arm_cnt <= r_arm_cnt + 1'b1;
      end
    end
  end

  // Handshake next-state: accept, replace on ack, or drop while unacked
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_drop      = 1'b0;
    w_take      = w_any & i_enable & r_armed;
    case (r_state)
      ST_IDLE: begin
        if (w_take) begin
          w_state_nxt = ST_PENDING;
          w_load      = 1'b1;
        end
      end
      ST_PENDING: begin
        if (i_event_ack) begin
          if (w_take) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (w_take) begin
          w_drop = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_ovf_set = w_drop | (w_load & w_multi);
  end

  // State register and event payload; payload only changes on a load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_hit   <= 1'b0;
      r_pos   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= (w_state_nxt == ST_PENDING);
      if (w_load) begin
        r_hit <= w_hit;
        r_pos <= w_pos;
      end
    end
  end

  // Sticky overflow; a new drop in the clearing cycle keeps it set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (i_clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  assign o_event_valid = r_valid;
  assign o_event_hit   = r_hit;
  assign o_event_pos   = r_pos;
  assign o_overflow    = r_ovf;

endmodule : switch_hit_detector
`default_nettype wire

// File: tb/tb_switch_hit_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_hit_detector
// Description : Directed scenarios plus random traffic for the switch hit
//               detector, checked every cycle against a history-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_hit_detector;

  localparam int N  = 18;
  localparam int PW = 5;
  localparam int D  = 4;
  localparam int CW = 4;
  localparam int HN = 8192;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  sw;
  logic [N-1:0]  tgt;
  logic          en;
  logic          ack;
  logic          clr;
  logic          o_valid;
  logic          o_hit;
  logic [PW-1:0] o_pos;
  logic [N-1:0]  o_stable;
  logic          o_ovf;

  switch_hit_detector #(
    .N_SW            (N),
    .POS_W           (PW),
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_switches    (sw),
    .i_target_led  (tgt),
    .i_enable      (en),
    .i_event_ack   (ack),
    .i_clr_ovf     (clr),
    .o_event_valid (o_valid),
    .o_event_hit   (o_hit),
    .o_event_pos   (o_pos),
    .o_sw_stable   (o_stable),
    .o_overflow    (o_ovf)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: raw switch history per edge since reset release
  logic [N-1:0] hist [0:HN-1];
  int           ek;
  logic [N-1:0] m_stable;
  logic [N-1:0] m_strobe;
  logic         m_valid;
  logic         m_hit;
  int           m_pos;
  logic         m_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [N-1:0] raw_at(input int k);
    if (k < 1) return '0;
    return hist[k % HN];
  endfunction

  task automatic model_reset();
    ek       = 0;
    m_stable = '0;
    m_strobe = '0;
    m_valid  = 1'b0;
    m_hit    = 1'b0;
    m_pos    = 0;
    m_ovf    = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs sampled there
  task automatic model_edge();
    logic         armed, take, set_ovf, all_diff;
    int           lo, cnt;
    logic [N-1:0] nstrobe, past;
    if (rst) begin
      model_reset();
      return;
    end
    ek++;
    armed   = ((ek - 1) >= D + 3);
    take    = (m_strobe != '0) && en && armed;
    set_ovf = 1'b0;
    if (take) begin
      lo = -1;
      for (int i = N - 1; i >= 0; i--) if (m_strobe[i]) lo = i;
      cnt = $countones(m_strobe);
      if (!m_valid || ack) begin
        m_valid = 1'b1;
        m_pos   = lo;
        m_hit   = tgt[lo];
        if (cnt > 1) set_ovf = 1'b1;
      end else begin
        set_ovf = 1'b1;
      end
    end else if (m_valid && ack) begin
      m_valid = 1'b0;
    end
    if (set_ovf) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    // A level commits once D consecutive synced samples disagree with it
    hist[ek % HN] = sw;
    nstrobe = '0;
    for (int b = 0; b < N; b++) begin
      all_diff = 1'b1;
      for (int j = 2; j <= D + 1; j++) begin
        past = raw_at(ek - j);
        if (past[b] == m_stable[b]) all_diff = 1'b0;
      end
      if (all_diff) begin
        m_stable[b] = ~m_stable[b];
        nstrobe[b]  = 1'b1;
      end
    end
    m_strobe = nstrobe;
  endtask

  task automatic compare_all();
    check("valid", 32'(o_valid), 32'(m_valid));
    if (m_valid) begin
      check("pos", 32'(o_pos), 32'(m_pos));
      check("hit", 32'(o_hit), 32'(m_hit));
    end
    check("ovf", 32'(o_ovf), 32'(m_ovf));
    check("stable", 32'(o_stable), 32'(m_stable));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    steps(3);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    sw  = '0;
    tgt = '0;
    en  = 1'b1;
    ack = 1'b0;
    clr = 1'b0;
    #2;
    do_reset();
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_stable", 32'(o_stable), 32'd0);
    steps(12);

    // 1: hit on sw[5], seven edges of latency
    tgt    = N'(1) << 5;
    sw[5]  = 1'b1;
    steps(6);
    check("t1_early", 32'(o_valid), 32'd0);
    step();
    check("t1_valid", 32'(o_valid), 32'd1);
    check("t1_pos", 32'(o_pos), 32'd5);
    check("t1_hit", 32'(o_hit), 32'd1);
    ack = 1'b1; step(); ack = 1'b0;
    check("t1_ack", 32'(o_valid), 32'd0);

    // 2: miss on sw[9]; short glitch on sw[3] is ignored
    sw[9] = 1'b1;
    steps(7);
    check("t2_pos", 32'(o_pos), 32'd9);
    check("t2_hit", 32'(o_hit), 32'd0);
    ack = 1'b1; step(); ack = 1'b0;
    sw[3] = 1'b1; steps(3); sw[3] = 1'b0;
    steps(10);
    check("t2_glitch", 32'(o_stable[3]), 32'd0);
    check("t2_noevt", 32'(o_valid), 32'd0);

    // 3: simultaneous toggles report the lowest index and overflow
    sw[2] = 1'b1; sw[7] = 1'b1;
    steps(7);
    check("t3_pos", 32'(o_pos), 32'd2);
    check("t3_ovf", 32'(o_ovf), 32'd1);
    ack = 1'b1; step(); ack = 1'b0;
    clr = 1'b1; step(); clr = 1'b0;
    check("t3_clr", 32'(o_ovf), 32'd0);

    // 4: drop while unacked, then ack coincident with the next strobe
    sw[9] = 1'b0;
    steps(7);
    check("t4_pos9", 32'(o_pos), 32'd9);
    sw[1] = 1'b1;
    steps(7);
    check("t4_held", 32'(o_pos), 32'd9);
    check("t4_ovf", 32'(o_ovf), 32'd1);
    clr = 1'b1; step(); clr = 1'b0;
    sw[1] = 1'b0;
    steps(6);
    ack = 1'b1; step(); ack = 1'b0;
    check("t4_b2b_valid", 32'(o_valid), 32'd1);
    check("t4_b2b_pos", 32'(o_pos), 32'd1);
    ack = 1'b1; step(); ack = 1'b0;

    // 5: switch up through reset is absorbed; enable low suppresses events
    sw[0] = 1'b1;
    do_reset();
    steps(12);
    check("t5_stable0", 32'(o_stable[0]), 32'd1);
    check("t5_noevt", 32'(o_valid), 32'd0);
    en = 1'b0; sw[4] = 1'b1;
    steps(10);
    check("t5_dis", 32'(o_valid), 32'd0);
    check("t5_stable4", 32'(o_stable[4]), 32'd1);
    en = 1'b1;

    // 6: reset while pending aborts the event; nothing until re-armed
    sw[6] = 1'b1;
    steps(7);
    check("t6_pend", 32'(o_valid), 32'd1);
    rst = 1'b1;
    model_reset();
    #1;
    check("t6_abort", 32'(o_valid), 32'd0);
    steps(2);
    rst = 1'b0;
    sw[8] = 1'b1;
    steps(10);
    check("t6_noevt", 32'(o_valid), 32'd0);
    check("t6_stable8", 32'(o_stable[8]), 32'd1);

    // Random traffic against the model
    for (int c = 0; c < 800; c++) begin
      if ($urandom % 10 == 0) sw = sw ^ (N'(1) << ($urandom % N));
      tgt = ($urandom % 4 == 0) ? '0 : (N'(1) << ($urandom % N));
      en  = ($urandom % 8 != 0);
      ack = ($urandom % 3 == 0);
      clr = ($urandom % 16 == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_switch_hit_detector
`default_nettype wire
